// File: rtl/fifo_flush_pack.sv
// Narrow-entry FIFO that, on a rising flush edge, drains a snapshot of its contents as packed wide
// words over a valid/ready port. Define FIFO_FLUSH_DROP_CNT_EN to enable the rejected-write counter.
module fifo_flush_pack #(
  parameter int unsigned       DATA_W = 4,
  parameter int unsigned       PACK   = 8,
  parameter int unsigned       DEPTH  = 32,
  parameter logic [DATA_W-1:0] PAD    = 4'hC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fifo_wr_valid_i,
  input  logic [DATA_W-1:0]          fifo_wr_data_i,
  input  logic                       fifo_flush_i,
  output logic                       fifo_rd_valid_o,
  input  logic                       fifo_rd_ready_i,
  output logic [DATA_W*PACK-1:0]     fifo_rd_data_o,
  output logic [$clog2(PACK):0]      fifo_rd_cnt_o,
  output logic                       fifo_flush_done_o,
  output logic [$clog2(DEPTH):0]     fifo_count_o,
  output logic                       fifo_empty_o,
  output logic                       fifo_full_o,
  output logic [15:0]                fifo_drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned KW = $clog2(PACK) + 1;

  typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          remaining_q, remaining_d;
  logic                   flush_q;
  logic                   flush_req, wr_accept, beat;
  logic [CW-1:0]          snapshot;
  logic [KW-1:0]          k;
  logic [DATA_W*PACK-1:0] lane_data;

  assign flush_req = fifo_flush_i & ~flush_q;
  assign wr_accept = fifo_wr_valid_i && (count_q < CW'(DEPTH));
  assign beat      = (state_q == StDrain) && fifo_rd_ready_i;
  // Snapshot includes a write accepted on the same edge as the request.
  assign snapshot  = count_q + CW'(wr_accept);
  assign k         = (remaining_q >= CW'(PACK)) ? KW'(PACK) : KW'(remaining_q);
  assign count_d   = count_q + CW'(wr_accept) - (beat ? CW'(k) : '0);

  always_comb begin
    remaining_d = remaining_q;
    if (state_q == StIdle && flush_req) begin
      remaining_d = snapshot;
    end else if (beat) begin
      remaining_d = remaining_q - CW'(k);
    end
  end

  for (genvar i = 0; i < PACK; i++) begin : g_lane
    logic [AW-1:0] idx;
    assign idx = rd_ptr_q + AW'(i);
    assign lane_data[i*DATA_W +: DATA_W] = (KW'(i) < k) ? mem_q[idx] : PAD;
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= fifo_wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      flush_q     <= 1'b0;
    end else begin
      flush_q     <= fifo_flush_i;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      if (wr_accept) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (beat)      rd_ptr_q <= rd_ptr_q + AW'(k);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (flush_req) state_d = (snapshot == '0) ? StDone : StDrain;
      StDrain: if (beat && remaining_q == CW'(k)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo_rd_valid_o   = 1'b0;
    fifo_rd_data_o    = '0;
    fifo_rd_cnt_o     = '0;
    fifo_flush_done_o = 1'b0;
    unique case (state_q)
      StDrain: begin
        fifo_rd_valid_o = 1'b1;
        fifo_rd_data_o  = lane_data;
        fifo_rd_cnt_o   = k;
      end
      StDone:  fifo_flush_done_o = 1'b1;
      default: ;
    endcase
  end

  assign fifo_count_o = count_q;
  assign fifo_empty_o = (count_q == '0);
  assign fifo_full_o  = (count_q == CW'(DEPTH));

`ifdef FIFO_FLUSH_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (fifo_wr_valid_i && fifo_full_o && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign fifo_drop_cnt_o = drop_cnt_q;
`else
  assign fifo_drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fifo_flush_pack.sv
// Scoreboard bench for fifo_flush_pack: stimulus queues expected beats, a monitor pops on handshakes.
module tb_fifo_flush_pack;

  logic        clk;
  logic        reset;
  logic        fifo_wr_valid_i;
  logic [3:0]  fifo_wr_data_i;
  logic        fifo_flush_i;
  logic        fifo_rd_valid_o;
  logic        fifo_rd_ready_i;
  logic [31:0] fifo_rd_data_o;
  logic [3:0]  fifo_rd_cnt_o;
  logic        fifo_flush_done_o;
  logic [5:0]  fifo_count_o;
  logic        fifo_empty_o;
  logic        fifo_full_o;
  logic [15:0] fifo_drop_cnt_o;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  cnt;
  } beat_t;

  beat_t sb[$];
  beat_t exp_beat;
  int    n_total = 0;
  int    n_pass  = 0;
  int    done_seen = 0;
  int    d0;

`ifdef FIFO_FLUSH_DROP_CNT_EN
  localparam logic [15:0] ExpDrop = 16'd1;
`else
  localparam logic [15:0] ExpDrop = 16'd0;
`endif

  fifo_flush_pack #(
    .DATA_W(4),
    .PACK  (8),
    .DEPTH (32),
    .PAD   (4'hC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_wr_valid_i  (fifo_wr_valid_i),
    .fifo_wr_data_i   (fifo_wr_data_i),
    .fifo_flush_i     (fifo_flush_i),
    .fifo_rd_valid_o  (fifo_rd_valid_o),
    .fifo_rd_ready_i  (fifo_rd_ready_i),
    .fifo_rd_data_o   (fifo_rd_data_o),
    .fifo_rd_cnt_o    (fifo_rd_cnt_o),
    .fifo_flush_done_o(fifo_flush_done_o),
    .fifo_count_o     (fifo_count_o),
    .fifo_empty_o     (fifo_empty_o),
    .fifo_full_o      (fifo_full_o),
    .fifo_drop_cnt_o  (fifo_drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h", name, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (reset && fifo_flush_done_o) done_seen++;
    if (reset && fifo_rd_valid_o && fifo_rd_ready_i) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL beat_unexpected: got data %h cnt %0d, required no beat",
                 fifo_rd_data_o, fifo_rd_cnt_o);
      end else begin
        exp_beat = sb.pop_front();
        check("beat_data", fifo_rd_data_o, exp_beat.data);
        check("beat_cnt", fifo_rd_cnt_o, exp_beat.cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int v);
    fifo_wr_valid_i = 1'b1;
    fifo_wr_data_i  = 4'(v);
    tick();
    fifo_wr_valid_i = 1'b0;
  endtask

  task automatic flush_pulse();
    fifo_flush_i = 1'b1;
    tick();
    fifo_flush_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] c);
    sb.push_back('{data: d, cnt: c});
  endtask

  // Bounded wait for the done pulse, then step one cycle so the FSM is back in idle.
  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (!fifo_flush_done_o && n < limit) begin
      tick();
      n++;
    end
    check(name, fifo_flush_done_o, 1);
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_valid"}, fifo_rd_valid_o, 0);
    check({tag, "_rd_data"}, fifo_rd_data_o, 0);
    check({tag, "_rd_cnt"}, fifo_rd_cnt_o, 0);
    check({tag, "_done"}, fifo_flush_done_o, 0);
    check({tag, "_empty"}, fifo_empty_o, 1);
    check({tag, "_full"}, fifo_full_o, 0);
    check({tag, "_count"}, fifo_count_o, 0);
    check({tag, "_drop"}, fifo_drop_cnt_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b0;
    fifo_wr_valid_i = 1'b0;
    fifo_wr_data_i  = '0;
    fifo_flush_i    = 1'b0;
    fifo_rd_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b1;
    tick();

    // Three entries pack into one padded beat.
    write(1); write(2); write(3);
    check("three_count", fifo_count_o, 3);
    push(32'hCCCCC321, 4'd3);
    flush_pulse();
    check("first_beat_latency", fifo_rd_valid_o, 1);
    wait_done("three_done", 10);
    check("three_count_after", fifo_count_o, 0);
    check("three_empty_after", fifo_empty_o, 1);
    check("three_sb_drained", sb.size(), 0);

    // Twenty entries: 8,8,4 beats; a write during the drain is kept.
    for (int i = 0; i < 20; i++) write(i % 16);
    push(32'h76543210, 4'd8);
    push(32'hFEDCBA98, 4'd8);
    push(32'hCCCC3210, 4'd4);
    flush_pulse();
    write(5);
    wait_done("twenty_done", 10);
    check("twenty_retained", fifo_count_o, 1);
    check("twenty_sb_drained", sb.size(), 0);
    push(32'hCCCCCCC5, 4'd1);
    flush_pulse();
    wait_done("retained_done", 10);
    check("retained_count", fifo_count_o, 0);

    // Fill to full, overflow by one, drain four full beats across the wrap.
    for (int i = 0; i < 32; i++) write(i % 16);
    check("full_flag", fifo_full_o, 1);
    check("full_count", fifo_count_o, 32);
    write(0);
    check("overflow_count", fifo_count_o, 32);
    check("overflow_drop", fifo_drop_cnt_o, ExpDrop);
    push(32'h76543210, 4'd8);
    push(32'hFEDCBA98, 4'd8);
    push(32'h76543210, 4'd8);
    push(32'hFEDCBA98, 4'd8);
    flush_pulse();
    wait_done("full_done", 20);
    check("full_drained_count", fifo_count_o, 0);
    check("full_drained_empty", fifo_empty_o, 1);
    check("full_drained_full", fifo_full_o, 0);

    // Backpressure with the flush input held high throughout.
    fifo_rd_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) write(i);
    push(32'h76543210, 4'd8);
    push(32'hCCCCCC98, 4'd2);
    d0 = done_seen;
    fifo_flush_i = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", fifo_rd_valid_o, 1);
      check("bp_data", fifo_rd_data_o, 32'h76543210);
      check("bp_cnt", fifo_rd_cnt_o, 8);
      check("bp_count", fifo_count_o, 10);
      tick();
    end
    fifo_rd_ready_i = 1'b1;
    wait_done("bp_done", 10);
    repeat (10) tick();
    check("held_flush_one_done", done_seen - d0, 1);
    fifo_flush_i = 1'b0;
    tick();
    check("bp_count_after", fifo_count_o, 0);
    check("bp_sb_drained", sb.size(), 0);

    // Empty flush: done in the cycle after the request edge, no beat.
    d0 = done_seen;
    fifo_flush_i = 1'b1;
    tick();
    check("empty_flush_done", fifo_flush_done_o, 1);
    check("empty_flush_valid", fifo_rd_valid_o, 0);
    fifo_flush_i = 1'b0;
    tick();
    check("empty_flush_done_drop", fifo_flush_done_o, 0);
    repeat (3) tick();
    check("empty_flush_one_done", done_seen - d0, 1);

    // Second rising edge during the drain is ignored.
    fifo_rd_ready_i = 1'b0;
    for (int i = 0; i < 12; i++) write(i);
    push(32'h76543210, 4'd8);
    push(32'hCCCCBA98, 4'd4);
    d0 = done_seen;
    flush_pulse();
    tick();
    fifo_flush_i = 1'b1;
    tick();
    check("second_edge_cnt", fifo_rd_cnt_o, 8);
    check("second_edge_valid", fifo_rd_valid_o, 1);
    fifo_rd_ready_i = 1'b1;
    wait_done("second_edge_done", 10);
    fifo_flush_i = 1'b0;
    repeat (5) tick();
    check("second_edge_one_done", done_seen - d0, 1);
    check("second_edge_count", fifo_count_o, 0);
    check("second_edge_sb_drained", sb.size(), 0);

    // Reset mid-drain abandons the flush without a done pulse.
    fifo_rd_ready_i = 1'b0;
    for (int i = 0; i < 12; i++) write(i);
    flush_pulse();
    check("pre_reset_valid", fifo_rd_valid_o, 1);
    d0 = done_seen;
    reset = 1'b0;
    #2;
    check_idle_outputs("midreset");
    sb.delete();
    tick();
    reset = 1'b1;
    repeat (4) tick();
    check("midreset_no_done", done_seen - d0, 0);
    fifo_rd_ready_i = 1'b1;
    fifo_flush_i = 1'b1;
    tick();
    check("post_reset_empty_done", fifo_flush_done_o, 1);
    check("post_reset_no_valid", fifo_rd_valid_o, 0);
    fifo_flush_i = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
